// File: rtl/game_timer_pkg.sv
// Shared encodings for the Morse game timer sequencer.
package game_timer_pkg;

    localparam int unsigned STATE_W             = 3;
    localparam int unsigned TICK_CYCLES_DEFAULT = 50_000_000;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_RUN     = 3'd2,
        ST_PAUSE   = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_e;

endpackage

// File: rtl/tick_divider.sv
// Game-second divider: counts enabled cycles and flags the terminal count combinationally
// so the caller can register it alongside its own decisions.
module tick_divider #(
    parameter int unsigned TICK_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic tc_o
);

    localparam int unsigned DIV_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_CYCLES - 1);

    logic [DIV_W-1:0] div_q, div_d;

    assign tc_o = enable_i && (div_q == DIV_MAX);

    always_comb begin
        div_d = div_q;
        if (clear_i) begin
            div_d = '0;
        end else if (enable_i) begin
            div_d = (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/game_timer_ctrl.sv
// Countdown chain sequencer for the Morse game timer.
// Define GAME_TIMER_PAUSE_EN to enable the PAUSE state; otherwise pause is ignored.
module game_timer_ctrl
    import game_timer_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = TICK_CYCLES_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               pause,
    input  logic               chain_done,
    output logic               reconfig,
    output logic               borrow_dn,
    output logic               running,
    output logic               timeout,
    output logic [STATE_W-1:0] state_o
);

    state_e state_q, state_d;
    logic   reconfig_q, reconfig_d;
    logic   borrow_dn_q, borrow_dn_d;
    logic   running_q, running_d;
    logic   timeout_q, timeout_d;
    logic   div_clear, div_en, div_tc;

`ifndef GAME_TIMER_PAUSE_EN
    logic unused_pause;
    assign unused_pause = pause;
`endif

    tick_divider #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_tick_divider (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (div_clear),
        .enable_i (div_en),
        .tc_o     (div_tc)
    );

    always_comb begin
        state_d = state_q;
        div_en  = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:    if (start) state_d = ST_ARM;
                ST_ARM:     state_d = ST_RUN;
                ST_RUN: begin
                    if (start)           state_d = ST_ARM;
                    else if (chain_done) state_d = ST_TIMEOUT;
`ifdef GAME_TIMER_PAUSE_EN
                    else if (pause)      state_d = ST_PAUSE;
`endif
                    else                 div_en  = 1'b1;
                end
`ifdef GAME_TIMER_PAUSE_EN
                ST_PAUSE: begin
                    if (start)           state_d = ST_ARM;
                    else if (chain_done) state_d = ST_TIMEOUT;
                    else if (!pause)     state_d = ST_RUN;
                end
`endif
                ST_TIMEOUT: if (start) state_d = ST_ARM;
                default:    state_d = ST_IDLE;
            endcase
        end

        // Divider restarts from zero on every (re)load; holds through PAUSE and TIMEOUT.
        div_clear   = (state_d == ST_IDLE) || (state_d == ST_ARM) || (state_q == ST_ARM);
        reconfig_d  = (state_d == ST_ARM);
        borrow_dn_d = div_tc;
        running_d   = (state_d == ST_RUN);
        timeout_d   = (state_d == ST_TIMEOUT);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            reconfig_q  <= 1'b0;
            borrow_dn_q <= 1'b0;
            running_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            reconfig_q  <= reconfig_d;
            borrow_dn_q <= borrow_dn_d;
            running_q   <= running_d;
            timeout_q   <= timeout_d;
        end
    end

    assign reconfig  = reconfig_q;
    assign borrow_dn = borrow_dn_q;
    assign running   = running_q;
    assign timeout   = timeout_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Directed bench for game_timer_ctrl with TICK_CYCLES=4; honours GAME_TIMER_PAUSE_EN.
module tb_game_timer_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       pause = 1'b0;
    logic       chain_done = 1'b0;
    logic       reconfig, borrow_dn, running, timeout;
    logic [2:0] state_o;

    int errors = 0;
    int checks = 0;

    game_timer_ctrl #(
        .TICK_CYCLES (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .pause      (pause),
        .chain_done (chain_done),
        .reconfig   (reconfig),
        .borrow_dn  (borrow_dn),
        .running    (running),
        .timeout    (timeout),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    // {state_o, reconfig, borrow_dn, running, timeout}
    function automatic logic [6:0] outs();
        return {state_o, reconfig, borrow_dn, running, timeout};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT just after the RUN entry edge with a cleared divider.
    task automatic go();
        abort = 1'b1; step(); abort = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b1;
        step(); step();
        checks++;
        if (outs() !== 7'b000_0000) begin
            errors++; $display("FAIL reset: got %b want %b", outs(), 7'b000_0000);
        end
        rst = 1'b1;
        step();
        checks++;
        if (outs() !== 7'b001_1000) begin
            errors++; $display("FAIL reset_release_arm: got %b want %b", outs(), 7'b001_1000);
        end
        start = 1'b0;
        step();
        checks++;
        if (outs() !== 7'b010_0010) begin
            errors++; $display("FAIL reset_release_run: got %b want %b", outs(), 7'b010_0010);
        end
    endtask

    task automatic test_cadence();
        logic [6:0] exp;
        go();
        for (int i = 1; i <= 20; i++) begin
            step();
            exp = {3'd2, 1'b0, ((i % 4) == 0), 1'b1, 1'b0};
            checks++;
            if (outs() !== exp) begin
                errors++; $display("FAIL cadence edge %0d: got %b want %b", i, outs(), exp);
            end
        end
    endtask

    task automatic test_timeout();
        go();
        step(); step(); step();
        chain_done = 1'b1;
        step();
        checks++;
        if (outs() !== 7'b100_0001) begin
            errors++; $display("FAIL timeout_at_terminal: got %b want %b", outs(), 7'b100_0001);
        end
        chain_done = 1'b0;
        step(); step();
        checks++;
        if (outs() !== 7'b100_0001) begin
            errors++; $display("FAIL timeout_hold: got %b want %b", outs(), 7'b100_0001);
        end
        start = 1'b1;
        step();
        checks++;
        if (outs() !== 7'b001_1000) begin
            errors++; $display("FAIL timeout_restart: got %b want %b", outs(), 7'b001_1000);
        end
        start = 1'b0;
        step();
        chain_done = 1'b1;
        step();
        chain_done = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if (outs() !== 7'b000_0000) begin
            errors++; $display("FAIL timeout_abort: got %b want %b", outs(), 7'b000_0000);
        end
    endtask

    task automatic test_pause();
        go();
        step(); step();
        pause = 1'b1;
`ifdef GAME_TIMER_PAUSE_EN
        for (int i = 1; i <= 10; i++) begin
            step();
            checks++;
            if (outs() !== 7'b011_0000) begin
                errors++; $display("FAIL pause_hold %0d: got %b want %b", i, outs(), 7'b011_0000);
            end
        end
        pause = 1'b0;
        step();
        checks++;
        if (outs() !== 7'b010_0010) begin
            errors++; $display("FAIL pause_resume: got %b want %b", outs(), 7'b010_0010);
        end
        step();
        checks++;
        if (outs() !== 7'b010_0010) begin
            errors++; $display("FAIL pause_resume_plus1: got %b want %b", outs(), 7'b010_0010);
        end
        step();
        checks++;
        if (outs() !== 7'b010_0110) begin
            errors++; $display("FAIL pause_resume_plus2: got %b want %b", outs(), 7'b010_0110);
        end
        pause = 1'b1;
        step();
        chain_done = 1'b1;
        step();
        pause = 1'b0; chain_done = 1'b0;
        checks++;
        if (outs() !== 7'b100_0001) begin
            errors++; $display("FAIL pause_chain_done: got %b want %b", outs(), 7'b100_0001);
        end
`else
        for (int i = 1; i <= 10; i++) begin
            logic [6:0] exp;
            step();
            exp = {3'd2, 1'b0, (((i + 2) % 4) == 0), 1'b1, 1'b0};
            checks++;
            if (outs() !== exp) begin
                errors++; $display("FAIL pause_ignored %0d: got %b want %b", i, outs(), exp);
            end
        end
        pause = 1'b0;
`endif
    endtask

    task automatic test_priority();
        go();
        abort = 1'b1; start = 1'b1;
        step();
        checks++;
        if (outs() !== 7'b000_0000) begin
            errors++; $display("FAIL abort_over_start: got %b want %b", outs(), 7'b000_0000);
        end
        abort = 1'b0;
        step();
        start = 1'b0; chain_done = 1'b1;
        step();
        chain_done = 1'b0;
        checks++;
        if (outs() !== 7'b010_0010) begin
            errors++; $display("FAIL arm_ignores_chain: got %b want %b", outs(), 7'b010_0010);
        end
        start = 1'b1; chain_done = 1'b1;
        step();
        start = 1'b0; chain_done = 1'b0;
        checks++;
        if (outs() !== 7'b001_1000) begin
            errors++; $display("FAIL start_over_chain: got %b want %b", outs(), 7'b001_1000);
        end
    endtask

    task automatic test_back_to_back();
        abort = 1'b1; step(); abort = 1'b0;
        start = 1'b1;
        step(); step(); step();
        checks++;
        if (outs() !== 7'b001_1000) begin
            errors++; $display("FAIL held_start_rearm: got %b want %b", outs(), 7'b001_1000);
        end
        start = 1'b0;
        step(); step(); step(); step(); step();
        checks++;
        if (outs() !== 7'b010_0110) begin
            errors++; $display("FAIL after_restart_pulse: got %b want %b", outs(), 7'b010_0110);
        end
    endtask

    task automatic test_midrun_reset();
        go();
        step(); step(); step(); step();
        checks++;
        if (outs() !== 7'b010_0110) begin
            errors++; $display("FAIL midrun_pulse: got %b want %b", outs(), 7'b010_0110);
        end
        rst = 1'b0;
        step();
        checks++;
        if (outs() !== 7'b000_0000) begin
            errors++; $display("FAIL midrun_reset: got %b want %b", outs(), 7'b000_0000);
        end
        rst = 1'b1;
        step();
        checks++;
        if (outs() !== 7'b000_0000) begin
            errors++; $display("FAIL midrun_reset_idle: got %b want %b", outs(), 7'b000_0000);
        end
    endtask

    initial begin
        test_reset();
        test_cadence();
        test_timeout();
        test_pause();
        test_priority();
        test_back_to_back();
        test_midrun_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
